// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding and the
// request bundle that is muxed onto the single data_mem port.
package dm_port_arbiter_pkg;

    localparam int DM_ADDR_W = 32;
    localparam int DM_DATA_W = 64;

    typedef enum logic {
        S_PIPE = 1'b0,
        S_EXT  = 1'b1
    } dm_arb_state_e;

    typedef struct packed {
        logic                 wen;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_arb_fsm.sv
// Grant FSM: pipeline priority in S_PIPE, with a starvation counter that forces
// a bounded external burst (S_EXT) once the external side has waited too long.
module dm_arb_fsm
    import dm_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p_req,
    input  logic x_valid,
    output logic grant_p,
    output logic grant_x,
    output logic in_ext
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    dm_arb_state_e      state_reg, state_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [BEAT_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic               starved;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_PIPE;
            wait_cnt_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            S_PIPE: begin
                if (starved) begin
                    if (wait_cnt_reg != WAIT_W'(MAX_WAIT))
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    if (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1))
                        state_next = S_EXT;
                end else begin
                    wait_cnt_next = '0;
                end
            end
            S_EXT: begin
                wait_cnt_next = '0;
                // Burst ends when the master goes quiet or the beat budget is spent.
                if (!x_valid || beat_cnt_reg == BEAT_W'(BURST_LEN - 1)) begin
                    state_next    = S_PIPE;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_PIPE;
        endcase
    end

    always_comb begin
        grant_p = 1'b0;
        grant_x = 1'b0;
        case (state_reg)
            S_PIPE: begin
                grant_p = p_req;
                grant_x = !p_req && x_valid;
            end
            S_EXT:   grant_x = x_valid;
            default: ;
        endcase
    end

    assign in_ext  = (state_reg == S_EXT);
    assign starved = (state_reg == S_PIPE) && x_valid && !grant_x;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data_mem port between the MEM-stage pipeline and an external
// loader/debug master; routes the one-cycle-late read data back to its source.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_p_req,
    input  logic              i_p_wen,
    input  logic [ADDR_W-1:0] i_p_addr,
    input  logic [DATA_W-1:0] i_p_wdata,
    output logic              o_p_ready,
    input  logic              i_x_valid,
    input  logic              i_x_wen,
    input  logic [ADDR_W-1:0] i_x_addr,
    input  logic [DATA_W-1:0] i_x_wdata,
    output logic              o_x_ready,
    output logic              o_x_rvalid,
    output logic [DATA_W-1:0] o_x_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_p_rdata
);

    logic    grant_p, grant_x, in_ext;
    logic    x_rd_q;
    dm_req_t p_bus, x_bus, mem_bus;

    dm_arb_fsm #(
        .MAX_WAIT  (MAX_WAIT),
        .BURST_LEN (BURST_LEN)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .p_req   (i_p_req),
        .x_valid (i_x_valid),
        .grant_p (grant_p),
        .grant_x (grant_x),
        .in_ext  (in_ext)
    );

    assign p_bus = '{wen: i_p_wen, addr: DM_ADDR_W'(i_p_addr), wdata: DM_DATA_W'(i_p_wdata)};
    assign x_bus = '{wen: i_x_wen, addr: DM_ADDR_W'(i_x_addr), wdata: DM_DATA_W'(i_x_wdata)};

    // With no grant the pipeline address is still presented, only wen is gated.
    assign mem_bus     = grant_x ? x_bus : p_bus;
    assign o_mem_addr  = ADDR_W'(mem_bus.addr);
    assign o_mem_wdata = DATA_W'(mem_bus.wdata);
    assign o_mem_wen   = mem_bus.wen && (grant_x || grant_p) && !rst;

    // Ready stays high whenever the pipeline is not locked out, so an idle MEM
    // stage is never stalled by the arbiter.
    assign o_p_ready = !in_ext;
    assign o_x_ready = grant_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) x_rd_q <= 1'b0;
        else     x_rd_q <= grant_x && !i_x_wen;
    end

    assign o_x_rvalid = x_rd_q;
    assign o_x_rdata  = i_mem_rdata;
    assign o_p_rdata  = i_mem_rdata;

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single data-memory port between the MEM-stage pipeline requester and an external loader/debug requester using a valid/ready handshake. The pipeline has priority. The external port is served opportunistically in idle cycles, and also through a starvation-driven burst that stalls the pipeline. It sits between `dm_store_controller` and `data_mem`, and returns read data to whichever source issued the read.

## Interface
- `ADDR_W`, 32, byte address width on all ports.
- `DATA_W`, 64, data width of the memory word.
- `MAX_WAIT`, 8, consecutive ungranted external-valid cycles that force a burst (≥1).
- `BURST_LEN`, 4, maximum external beats per forced burst (≥1).
- One clock; reset is asynchronous and active-high.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_p_req` in 1: pipeline access this cycle (`mem_rd_en | mem_wr_en`).
- `i_p_wen` in 1: pipeline write.
- `i_p_addr` in ADDR_W: pipeline address.
- `i_p_wdata` in DATA_W: pipeline write data.
- `o_p_ready` out 1: pipeline access accepted; low = MEM stage stalls (ANDed into `o_mem_ready`).
- `i_x_valid` in 1: external request pending.
- `i_x_wen` in 1: external write.
- `i_x_addr` in ADDR_W: external address.
- `i_x_wdata` in DATA_W: external write data.
- `o_x_ready` out 1: external beat accepted this cycle.
- `o_x_rvalid` out 1: external read data valid.
- `o_x_rdata` out DATA_W: external read data.
- `o_mem_addr` out ADDR_W: to `data_mem`.
- `o_mem_wen` out 1: to `data_mem`.
- `o_mem_wdata` out DATA_W: to `data_mem`.
- `i_mem_rdata` in DATA_W: from `data_mem`, one cycle after address.
- `o_p_rdata` out DATA_W: pipeline read data, passthrough of `i_mem_rdata`.

## Operation
- FSM states are S_PIPE and S_EXT. Reset state is S_PIPE.
- **Grant in S_PIPE:**
  - `i_p_req` → pipeline is granted, `o_p_ready`=1.
  - Else `i_x_valid` → external is granted opportunistically, `o_x_ready`=1.
  - Otherwise no grant: `o_mem_wen`=0, `o_mem_addr`=`i_p_addr`.
- **Grant in S_EXT:** external is granted whenever `i_x_valid`, and `o_p_ready`=0.
- **wait_cnt:**
  - Increments in S_PIPE when `i_x_valid` is high and not granted.
  - Clears on any external grant, or when `i_x_valid`=0.
  - Saturates at `MAX_WAIT`.
- **S_PIPE→S_EXT:** when wait_cnt reaches `MAX_WAIT`-1 and an increment occurs. S_EXT starts the next cycle.
- **beat_cnt:** counts external accepts in S_EXT.
- **S_EXT→S_PIPE:** on the beat_cnt=`BURST_LEN`-1 accept, or on any S_EXT cycle with `i_x_valid`=0. beat_cnt and wait_cnt clear on exit.
- **Write gating:** `o_mem_wen` = granted source's wen & grant. It is forced 0 while `rst` is high.
- **Handshake:** the external side holds valid, addr, wdata and wen stable until ready. A beat transfers on valid&ready.
- **Read return:** a flop `x_rd_q` = (external granted & !`i_x_wen`). `o_x_rvalid`=`x_rd_q`, `o_x_rdata`=`i_mem_rdata`.
- **Simultaneous pipeline and external in S_PIPE:** the pipeline wins unless the FSM is already in S_EXT. An external write and a pipeline read of the same address never share a cycle, so there is no forwarding.

## Timing
- Grant, ready and memory-port outputs are combinational from state and inputs. The memory samples at the next `clk` edge.
- External read: accept at cycle N → `o_x_rvalid`=1 with data at N+1. Back-to-back reads give one rvalid per cycle.
- Forced burst: the starvation threshold is hit at cycle N → S_EXT at N+1 → pipeline stalled for at most `BURST_LEN` cycles.
- Reset values: state S_PIPE, wait_cnt 0, beat_cnt 0, `o_x_rvalid` 0. Combinational outputs follow S_PIPE rules with wen forced 0.
- Reset mid-burst: return to S_PIPE immediately; any pending rvalid is dropped. The external master must reissue.
- `MAX_WAIT`=1: a forced burst follows the first starved cycle.

## Structure
- Shared package (alongside `interconnection_struct`):
  - state enum `dm_arb_state_e` {S_PIPE, S_EXT}.
  - `dm_req_t` struct (wen, addr, wdata).
- Sub-module `dm_arb_fsm`: state register, wait_cnt and beat_cnt, outputs `grant_x`/`grant_p`.
- Top level: the address/data mux and the rvalid flop.

## Test plan
- **Pipeline only:** `i_p_req`=1 every cycle, addr 0x40/0x48 writes → `o_mem_wen`=1 each cycle, `o_p_ready` never 0, `o_x_ready`=0.
- **Opportunistic read:** pipeline idle, external read of 0x100 → `o_x_ready`=1 same cycle, `o_x_rvalid`=1 with mem[0x100] the next cycle.
- **Starvation:** `i_p_req` stuck 1 and `i_x_valid`=1 with MAX_WAIT=8, BURST_LEN=4 → after 8 starved cycles, `o_p_ready`=0 for exactly 4 cycles with 4 external beats, then pipeline resumes.
- **Burst early end:** in S_EXT, `i_x_valid` drops after 2 beats → S_PIPE next cycle, `o_p_ready`=1.
- **Reset mid-burst:** `rst` pulse during beat 2 → `o_x_rvalid`=0, `o_mem_wen`=0 while reset is high, S_PIPE after release.
